// File: rtl/aes_encrypt_sequencer_pkg.sv
// Shared AES-128 definitions: widths, round count, sequencer state encoding and
// the byte-level GF(2^8) helpers used by the round and key-schedule logic.
package aes_defs;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_KEY_W   = 128;
   localparam int AES_ROUNDS  = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } aes_fsm_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box derived from its definition: inverse as a^254 (0 maps to 0), then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] p;
      logic [7:0] inv;
      p   = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         p   = gf_mul(p, p);
         inv = gf_mul(inv, p);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

endpackage

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule: expands the cipher key into all eleven round keys
// combinationally; round key 0 is the key itself.
module aes_key_expansion
   import aes_defs::*;
(
   input  logic [AES_KEY_W-1:0]                    i_key,
   output logic [AES_ROUNDS:0][AES_BLOCK_W-1:0]    o_round_keys
);

   logic [31:0] w_words [4*(AES_ROUNDS+1)];
   logic [31:0] w_temp;
   logic [7:0]  w_rcon;

   always_comb begin
      w_temp = '0;
      w_rcon = 8'h01;
      for (int i = 0; i < 4; i++) begin
         w_words[i] = i_key[AES_KEY_W-1-32*i -: 32];
      end
      for (int i = 4; i < 4*(AES_ROUNDS+1); i++) begin
         w_temp = w_words[i-1];
         if ((i % 4) == 0) begin
            w_temp = sub_word({w_temp[23:0], w_temp[31:24]}) ^ {w_rcon, 24'h000000};
            w_rcon = xtime(w_rcon);
         end
         w_words[i] = w_words[i-4] ^ w_temp;
      end
   end

   always_comb begin
      o_round_keys = '0;
      for (int r = 0; r <= AES_ROUNDS; r++) begin
         o_round_keys[r] = {w_words[4*r], w_words[4*r+1], w_words[4*r+2], w_words[4*r+3]};
      end
   end

endmodule

// File: rtl/aes_round_unit.sv
// One AES round: SubBytes, ShiftRows, MixColumns, AddRoundKey; MixColumns is
// bypassed when i_final is set. Byte 0 of the state sits in bits [127:120].
module aes_round_unit
   import aes_defs::*;
(
   input  logic [AES_BLOCK_W-1:0] i_state,
   input  logic [AES_BLOCK_W-1:0] i_round_key,
   input  logic                   i_final,
   output logic [AES_BLOCK_W-1:0] o_next_state
);

   logic [7:0] w_sb [16];
   logic [7:0] w_sr [16];
   logic [7:0] w_mc [16];
   logic [7:0] w_a0, w_a1, w_a2, w_a3;

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         w_sb[i] = sbox(i_state[AES_BLOCK_W-1-8*i -: 8]);
      end
   end

   // Column-major state: byte 4*c+r is row r of column c; row r rotates left by r.
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
         end
      end
   end

   always_comb begin
      w_a0 = '0;
      w_a1 = '0;
      w_a2 = '0;
      w_a3 = '0;
      for (int c = 0; c < 4; c++) begin
         w_a0 = w_sr[4*c];
         w_a1 = w_sr[4*c+1];
         w_a2 = w_sr[4*c+2];
         w_a3 = w_sr[4*c+3];
         w_mc[4*c]   = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
         w_mc[4*c+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
         w_mc[4*c+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
         w_mc[4*c+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
      end
   end

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         o_next_state[AES_BLOCK_W-1-8*i -: 8] =
            (i_final ? w_sr[i] : w_mc[i]) ^ i_round_key[AES_BLOCK_W-1-8*i -: 8];
      end
   end

endmodule

// File: rtl/aes_encrypt_sequencer.sv
// Iterative AES-128 encryptor: one round per clock, valid/ready on both sides,
// ciphertext exposed only in DONE.
module aes_encrypt_sequencer
   import aes_defs::*;
#(
   parameter int ROUNDS = AES_ROUNDS
)
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_BLOCK_W-1:0] in_data,
   input  logic [AES_KEY_W-1:0]   in_key,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_BLOCK_W-1:0] out_data,
   output logic                   busy,
   output logic [3:0]             round_idx,
   output logic [1:0]             o_dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready, and DONE may accept a new block
   // on the same edge its ciphertext is taken.
   aes_fsm_e                r_fsm, w_fsm_nxt;
   logic [AES_BLOCK_W-1:0]  r_state, w_state_nxt;
   logic [AES_KEY_W-1:0]    r_key, w_key_nxt;
   logic [3:0]              r_cnt, w_cnt_nxt;

   logic [AES_ROUNDS:0][AES_BLOCK_W-1:0] w_round_keys;
   logic [AES_BLOCK_W-1:0]  w_round_key;
   logic [AES_BLOCK_W-1:0]  w_round_out;
   logic                    w_final;
   logic                    w_accept;

   aes_key_expansion u_key_expansion (
      .i_key        (r_key),
      .o_round_keys (w_round_keys)
   );

   assign w_round_key = w_round_keys[r_cnt];
   assign w_final     = (r_fsm == FINAL);

   aes_round_unit u_round_unit (
      .i_state      (r_state),
      .i_round_key  (w_round_key),
      .i_final      (w_final),
      .o_next_state (w_round_out)
   );

   assign in_ready    = !rst && ((r_fsm == IDLE) || ((r_fsm == DONE) && out_ready));
   assign w_accept    = in_valid && in_ready;
   assign out_valid   = (r_fsm == DONE);
   assign out_data    = (r_fsm == DONE) ? r_state : '0;
   assign busy        = (r_fsm == ROUND) || (r_fsm == FINAL);
   assign round_idx   = busy ? r_cnt : 4'd0;
   assign o_dbg_state = r_fsm;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm   <= IDLE;
         r_state <= '0;
         r_key   <= '0;
         r_cnt   <= '0;
      end else begin
         r_fsm   <= w_fsm_nxt;
         r_state <= w_state_nxt;
         r_key   <= w_key_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_fsm_nxt   = r_fsm;
      w_state_nxt = r_state;
      w_key_nxt   = r_key;
      w_cnt_nxt   = r_cnt;
      case (r_fsm)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = in_data ^ in_key;
               w_key_nxt   = in_key;
               w_cnt_nxt   = 4'd1;
               w_fsm_nxt   = ROUND;
            end
         end
         ROUND: begin
            w_state_nxt = w_round_out;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'(ROUNDS - 1)) w_fsm_nxt = FINAL;
         end
         FINAL: begin
            w_state_nxt = w_round_out;
            w_cnt_nxt   = 4'd0;
            w_fsm_nxt   = DONE;
         end
         DONE: begin
            if (w_accept) begin
               w_state_nxt = in_data ^ in_key;
               w_key_nxt   = in_key;
               w_cnt_nxt   = 4'd1;
               w_fsm_nxt   = ROUND;
            end else if (out_ready) begin
               w_fsm_nxt = IDLE;
            end
         end
         default: w_fsm_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_aes_encrypt_sequencer.sv
// Directed bench for aes_encrypt_sequencer using FIPS-197 known-answer vectors.
module tb_aes_encrypt_sequencer;
   import aes_defs::*;

   localparam logic [127:0] KA = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PA = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [127:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;
   logic [3:0]   round_idx;
   logic [1:0]   dbg_state;

   int n_checks = 0;
   int n_fails  = 0;
   int n_out    = 0;
   int cyc      = 0;
   logic [127:0] exp_q[$];

   aes_encrypt_sequencer #(.ROUNDS(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_key      (in_key),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy),
      .round_idx   (round_idx),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h required %h", tag, got, exp);
      end
   endtask

   // scoreboard: every taken ciphertext is matched against the expected queue
   always @(negedge clk) begin
      if (!rst) begin
         if (!out_valid) check("masked_data", out_data, 128'd0);
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check("unexpected_out", 128'd1, 128'd0);
            else check("ciphertext", out_data, exp_q.pop_front());
         end
      end
   end

   // driver tasks: called at posedge+1, return at posedge+1
   task automatic send(input logic [127:0] d, input logic [127:0] k,
                       input logic [127:0] c, input bit hold);
      int guard;
      in_valid = 1'b1;
      in_data  = d;
      in_key   = k;
      guard    = 0;
      while (!in_ready && guard < 40) begin
         @(posedge clk); #1;
         guard++;
      end
      check("accept_ready", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      exp_q.push_back(c);
      if (!hold) in_valid = 1'b0;
   endtask

   task automatic wait_done(input int start, output int lat);
      lat = start;
      while (!out_valid && lat < 30) begin
         if (lat <= 9) begin
            check("round_idx", 128'(round_idx), 128'(lat + 1));
            check("busy", 128'(busy), 128'd1);
         end
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 128'(lat), 128'd10);
   endtask

   initial begin
      int lat, lat2, t1, t2, guard;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_key    = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 128'(in_ready), 128'd0);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_out_data", out_data, 128'd0);
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_round_idx", 128'(round_idx), 128'd0);
      #2 rst = 1'b0;
      #1 check("post_rst_ready", 128'(in_ready), 128'd1);
      @(posedge clk); #1;

      // known-answer vector A with immediate consumer
      send(PA, KA, CA, 1'b0);
      wait_done(0, lat);
      @(posedge clk); #1;
      check("a_idle_state", 128'(dbg_state), 128'(IDLE));
      check("a_idle_valid", 128'(out_valid), 128'd0);

      // vector B with consumer stalled for 5 cycles
      out_ready = 1'b0;
      send(PB, KB, CB, 1'b0);
      wait_done(0, lat);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", 128'(out_valid), 128'd1);
         check("hold_data", out_data, CB);
         check("hold_in_ready", 128'(in_ready), 128'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("b_idle_state", 128'(dbg_state), 128'(IDLE));
      check("b_idle_in_ready", 128'(in_ready), 128'd1);

      // back-to-back A then B, second taken on the DONE edge
      send(PA, KA, CA, 1'b1);
      in_data = PB;
      in_key  = KB;
      wait_done(0, lat);
      t1 = cyc;
      check("b2b_in_ready", 128'(in_ready), 128'd1);
      @(posedge clk); #1;
      exp_q.push_back(CB);
      in_valid = 1'b0;
      check("b2b_busy", 128'(busy), 128'd1);
      check("b2b_round_idx", 128'(round_idx), 128'd1);
      wait_done(0, lat2);
      t2 = cyc;
      check("b2b_spacing", 128'(t2 - t1), 128'd11);
      @(posedge clk); #1;

      // inputs toggled while busy must be ignored
      send(PB, KB, CB, 1'b0);
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = {$urandom, $urandom, $urandom, $urandom};
         in_key  = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         check("toggle_round_idx", 128'(round_idx), 128'(i + 2));
      end
      in_valid = 1'b0;
      wait_done(6, lat);
      @(posedge clk); #1;

      // reset in the middle of round 5
      send(PA, KA, CA, 1'b0);
      guard = 0;
      while (round_idx != 4'd5 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("mid_round_idx", 128'(round_idx), 128'd5);
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("mid_rst_valid", 128'(out_valid), 128'd0);
      check("mid_rst_data", out_data, 128'd0);
      check("mid_rst_busy", 128'(busy), 128'd0);
      check("mid_rst_round_idx", 128'(round_idx), 128'd0);
      check("mid_rst_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk); #2 rst = 1'b0;
      @(posedge clk); #1;
      check("after_rst_busy", 128'(busy), 128'd0);
      check("after_rst_valid", 128'(out_valid), 128'd0);
      send(PA, KA, CA, 1'b0);
      wait_done(0, lat);
      @(posedge clk); #1;

      // final report
      check("out_count", 128'(n_out), 128'd6);
      check("queue_empty", 128'(exp_q.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/aes_encrypt_sequencer.md
AES_ENCRYPT_SEQUENCER -- requirements
Module: aes_encrypt_sequencer

Interface
REQ-001 The module SHALL have parameter ROUNDS, default 10, meaning the AES-128 round count; only 10 is supported.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: plaintext/key offered.
REQ-005 The module SHALL have port in_ready, output, 1 bit: block can accept a plaintext/key.
REQ-006 The module SHALL have port in_data, input, 128 bits: plaintext, same byte ordering as the existing round primitives.
REQ-007 The module SHALL have port in_key, input, 128 bits: cipher key.
REQ-008 The module SHALL have port out_valid, output, 1 bit: ciphertext available.
REQ-009 The module SHALL have port out_ready, input, 1 bit: consumer accepts the ciphertext.
REQ-010 The module SHALL have port out_data, output, 128 bits: ciphertext.
REQ-011 The module SHALL have port busy, output, 1 bit: encryption in progress (ROUND or FINAL).
REQ-012 The module SHALL have port round_idx, output, 4 bits: current round number, 0 when not busy.

Function
REQ-013 The FSM SHALL have states IDLE, ROUND, FINAL and DONE, with one 128-bit state register, one 128-bit key register and a 4-bit round counter.
REQ-014 in_ready SHALL equal (FSM==IDLE) or (FSM==DONE and out_ready); a transfer occurs on a clock edge with in_valid and in_ready both high.
REQ-015 On an input transfer, the state register SHALL load in_data XOR in_key, the key register SHALL load in_key, the counter SHALL load 1, and the FSM SHALL go to ROUND.
REQ-016 In ROUND, each edge SHALL apply a full round (SubBytes, ShiftRows, MixColumns, AddRoundKey) with round key[counter] and increment the counter; at counter 9 the FSM SHALL go to FINAL.
REQ-017 In FINAL, one edge SHALL apply SubBytes, ShiftRows and AddRoundKey with round key 10 (no MixColumns), then the FSM SHALL go to DONE.
REQ-018 Round keys SHALL come from an expanded schedule of the key register, indexed by the counter; round key 0 equals the key.
REQ-019 In DONE, out_valid SHALL be 1 and out_data SHALL equal the state register; at all other times out_data SHALL be forced to 0, so intermediate state is never exposed.
REQ-020 Latency SHALL be 10 edges from the accept edge to out_valid high; back-to-back throughput SHALL be one block per 11 cycles.
REQ-021 In DONE with out_ready low, out_valid and out_data SHALL hold stable indefinitely.
REQ-022 In DONE with out_ready high and in_valid low, the FSM SHALL go to IDLE.
REQ-023 In DONE with out_ready and in_valid both high, the output transfer and the new input transfer SHALL occur on the same edge, and the FSM SHALL go directly to ROUND.
REQ-024 in_valid, in_data and in_key SHALL be ignored while busy; input changes SHALL not affect an in-flight block.
REQ-025 busy SHALL be 1 exactly in ROUND and FINAL; round_idx SHALL show the counter (1..10) when busy, otherwise 0.

Reset
REQ-026 While rst is high, FSM=IDLE, state/key registers=0, counter=0, out_valid=0, out_data=0, busy=0 and round_idx=0; in_ready SHALL be 0 during reset and 1 from the first cycle after deassertion.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight block immediately, with no partial output ever produced.

Structure
REQ-028 Shared package aes_defs SHALL hold: AES_BLOCK_W=128, AES_KEY_W=128, AES_ROUNDS=10, and the FSM state encoding.
REQ-029 The existing KeyExpansion block SHALL be instanced for the schedule.
REQ-030 One new sub-module, aes_round_unit (inputs: state, round key, final flag; output: next state), SHALL wrap the existing SubBytes/ShiftRows/MixColumns/AddRoundKey primitives and bypass MixColumns when final=1.

Verification
REQ-031 Key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff -> out_valid exactly 10 edges after accept, out_data 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-032 Key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734, out_ready low for 5 cycles -> 3925841d02dc09fbdc118597196a0b32 held stable, in_ready 0, then IDLE after the out_ready edge.
REQ-033 Both vectors above back-to-back with in_valid and out_ready held high -> second accepted on the first DONE edge, outputs 11 cycles apart, both correct.
REQ-034 rst pulsed when round_idx=5 -> out_valid, out_data, busy and round_idx all 0 at once; a following REQ-031 vector still yields the correct result.
REQ-035 in_data/in_key toggled with in_valid high during ROUND -> no extra accept, ciphertext unchanged, out_data 0 whenever out_valid=0.
